// File: rtl/eth_pkg.sv
// Shared Ethernet constants, receive-FSM state type and small helpers.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    // Residue in the non-reflected (MSB-first) orientation.
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;
    localparam int unsigned HDR_LEN       = 14;
    localparam int unsigned FCS_LEN       = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_HEADER   = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_DROP     = 3'd4
    } rx_state_t;

    // The CRC register is kept in reflected (LSB-first) order, so it has to
    // be bit-reversed before it can be compared against CRC_RESIDUE.
    function automatic logic [31:0] bitrev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Combinational next-state of the reflected Ethernet CRC-32 for one byte,
// data consumed LSB first. Shared by the receive and transmit MACs.
module crc32_d8 (
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    // Reflected form of polynomial 04C11DB7.
    localparam logic [31:0] POLY_REFL = 32'hEDB8_8320;

    logic [31:0] stage [0:8];

    assign stage[0] = crc_in;

    // One shift/conditional-xor stage per data bit.
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        logic fb;
        assign fb           = stage[gi][0] ^ data_in[gi];
        assign stage[gi+1]  = {1'b0, stage[gi][31:1]} ^ (fb ? POLY_REFL : 32'h0);
    end

    assign crc_out = stage[8];

endmodule

// File: rtl/gmii_rx_mac.sv
// GMII receive MAC: strips preamble/SFD, filters on destination MAC, checks
// the FCS and forwards the payload with the trailing FCS bytes removed.
module gmii_rx_mac
    import eth_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter int unsigned MAX_FRAME = 1518,
    parameter int unsigned MIN_FRAME = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic [15:0] eth_type,
    output logic [47:0] src_mac,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [10:0] frame_len
);

    localparam int unsigned OVERHEAD = HDR_LEN + FCS_LEN;
    localparam logic [10:0] MAX_PAY  = 11'(MAX_FRAME - OVERHEAD);
    localparam logic [10:0] MIN_PAY  = 11'(MIN_FRAME - OVERHEAD);

    rx_state_t        state_q, state_d;
    logic [2:0]       pre_cnt_q, pre_cnt_d;
    logic [3:0]       hdr_cnt_q, hdr_cnt_d;
    logic [103:0]     hdr_q, hdr_d;          // previous 13 header bytes
    logic [31:0]      crc_q, crc_d;
    logic [3:0][7:0]  line_q, line_d;        // [3] is the oldest byte
    logic [2:0]       line_cnt_q, line_cnt_d;
    logic [10:0]      out_cnt_q, out_cnt_d;
    logic             err_q, err_d;          // sticky oversize flag

    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_sof_q, out_sof_d;
    logic [15:0]      eth_type_q, eth_type_d;
    logic [47:0]      src_mac_q, src_mac_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_ok_q, frame_ok_d;
    logic [10:0]      frame_len_q, frame_len_d;

    logic [31:0]      crc_next;
    logic [111:0]     hdr_full;
    logic             crc_good;
    logic             len_legal;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data_in (gmii_rxd),
        .crc_out (crc_next)
    );

    assign hdr_full  = {hdr_q, gmii_rxd};
    assign crc_good  = (bitrev32(crc_q) == CRC_RESIDUE);
    assign len_legal = !err_q && (out_cnt_q >= MIN_PAY) && (out_cnt_q <= MAX_PAY);

    // Next-state and datapath decode; every target defaults to hold/idle.
    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        hdr_cnt_d    = hdr_cnt_q;
        hdr_d        = hdr_q;
        crc_d        = crc_q;
        line_d       = line_q;
        line_cnt_d   = line_cnt_q;
        out_cnt_d    = out_cnt_q;
        err_d        = err_q;
        out_valid_d  = 1'b0;
        out_data_d   = out_data_q;
        out_sof_d    = 1'b0;
        eth_type_d   = eth_type_q;
        src_mac_d    = src_mac_q;
        frame_done_d = 1'b0;
        frame_ok_d   = 1'b0;
        frame_len_d  = frame_len_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == PREAMBLE_BYTE) begin
                        state_d   = ST_PREAMBLE;
                        pre_cnt_d = 3'd1;
                    end else begin
                        state_d   = ST_DROP;
                    end
                end
            end

            ST_PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_d = ST_IDLE;
                end else if (gmii_rxd == PREAMBLE_BYTE) begin
                    if (pre_cnt_q == 3'd7) begin
                        state_d = ST_DROP;
                    end else begin
                        pre_cnt_d = pre_cnt_q + 3'd1;
                    end
                end else if (gmii_rxd == SFD_BYTE && pre_cnt_q != 3'd0) begin
                    state_d   = ST_HEADER;
                    hdr_cnt_d = 4'd0;
                    crc_d     = CRC_INIT;
                end else begin
                    state_d = ST_DROP;
                end
            end

            ST_HEADER: begin
                if (!gmii_rx_dv) begin
                    state_d = ST_IDLE;
                end else begin
                    crc_d     = crc_next;
                    hdr_d     = hdr_full[103:0];
                    hdr_cnt_d = hdr_cnt_q + 4'd1;
                    if (hdr_cnt_q == 4'd5 &&
                        hdr_full[47:0] != BOARD_MAC &&
                        hdr_full[47:0] != BCAST_MAC) begin
                        state_d = ST_DROP;
                    end else if (hdr_cnt_q == 4'd13) begin
                        state_d    = ST_PAYLOAD;
                        src_mac_d  = hdr_full[63:16];
                        eth_type_d = hdr_full[15:0];
                        line_cnt_d = 3'd0;
                        out_cnt_d  = 11'd0;
                        err_d      = 1'b0;
                    end
                end
            end

            ST_PAYLOAD: begin
                if (gmii_rx_dv) begin
                    crc_d  = crc_next;
                    line_d = {line_q[2:0], gmii_rxd};
                    if (line_cnt_q != 3'd4) begin
                        line_cnt_d = line_cnt_q + 3'd1;
                    end else if (err_q || out_cnt_q == MAX_PAY) begin
                        // Oversize: swallow the rest of the frame silently.
                        err_d = 1'b1;
                    end else begin
                        out_valid_d = 1'b1;
                        out_data_d  = line_q[3];
                        out_sof_d   = (out_cnt_q == 11'd0);
                        out_cnt_d   = out_cnt_q + 11'd1;
                    end
                end else begin
                    // Whatever is left in the delay line is the FCS.
                    state_d      = ST_IDLE;
                    frame_done_d = 1'b1;
                    frame_ok_d   = crc_good && len_legal;
                    frame_len_d  = out_cnt_q;
                end
            end

            ST_DROP: begin
                if (!gmii_rx_dv) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q    <= '0;
            hdr_cnt_q    <= '0;
            hdr_q        <= '0;
            crc_q        <= CRC_INIT;
            line_q       <= '0;
            line_cnt_q   <= '0;
            out_cnt_q    <= '0;
            err_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_sof_q    <= 1'b0;
            eth_type_q   <= '0;
            src_mac_q    <= '0;
            frame_done_q <= 1'b0;
            frame_ok_q   <= 1'b0;
            frame_len_q  <= '0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            hdr_cnt_q    <= hdr_cnt_d;
            hdr_q        <= hdr_d;
            crc_q        <= crc_d;
            line_q       <= line_d;
            line_cnt_q   <= line_cnt_d;
            out_cnt_q    <= out_cnt_d;
            err_q        <= err_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_sof_q    <= out_sof_d;
            eth_type_q   <= eth_type_d;
            src_mac_q    <= src_mac_d;
            frame_done_q <= frame_done_d;
            frame_ok_q   <= frame_ok_d;
            frame_len_q  <= frame_len_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_sof    = out_sof_q;
    assign eth_type   = eth_type_q;
    assign src_mac    = src_mac_q;
    assign frame_done = frame_done_q;
    assign frame_ok   = frame_ok_q;
    assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_gmii_rx_mac.sv
// Directed testbench for gmii_rx_mac: builds frames with a real Ethernet
// FCS, drives them byte by byte and checks the payload stream and status.
module tb_gmii_rx_mac;

    localparam logic [47:0] BOARD = 48'h00_11_22_33_44_55;
    localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SRC1  = 48'h0A_0B_0C_0D_0E_0F;
    localparam logic [47:0] SRC2  = 48'h66_77_88_99_AA_BB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic [15:0] eth_type;
    logic [47:0] src_mac;
    logic        frame_done;
    logic        frame_ok;
    logic [10:0] frame_len;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] frm[$];     // bytes on the wire, preamble through FCS
    logic [7:0] exp_q[$];   // payload bytes as sent
    logic [7:0] rx_q[$];    // payload bytes seen at out_data
    int         sof_cnt;
    int         sof_pos;
    int         done_cnt;
    logic       last_ok;
    logic [10:0] last_len;

    gmii_rx_mac dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rxd   (gmii_rxd),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_sof    (out_sof),
        .eth_type   (eth_type),
        .src_mac    (src_mac),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .frame_len  (frame_len)
    );

    always #4 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (out_valid) begin
            if (out_sof) begin
                sof_cnt++;
                sof_pos = rx_q.size();
            end
            rx_q.push_back(out_data);
        end
        if (frame_done) begin
            done_cnt++;
            last_ok  = frame_ok;
            last_len = frame_len;
        end
    end

    task automatic build(input int npre, input logic [47:0] dst, input logic [47:0] src,
                         input logic [15:0] et, input int npay, input int flip_idx);
        logic [7:0]  body[$];
        logic [31:0] crc;
        logic [7:0]  b;
        frm.delete();
        exp_q.delete();
        for (int i = 0; i < npre; i++) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) body.push_back(dst[i*8 +: 8]);
        for (int i = 5; i >= 0; i--) body.push_back(src[i*8 +: 8]);
        body.push_back(et[15:8]);
        body.push_back(et[7:0]);
        for (int i = 0; i < npay; i++) body.push_back(8'(i));
        crc = 32'hFFFF_FFFF;
        foreach (body[i]) crc = crc_byte(crc, body[i]);
        crc = ~crc;
        for (int i = 0; i < 4; i++) body.push_back(crc[i*8 +: 8]);
        if (flip_idx >= 0) begin
            b = body[14 + flip_idx];
            body[14 + flip_idx] = b ^ 8'h01;
        end
        for (int i = 0; i < npay; i++) exp_q.push_back(body[14 + i]);
        foreach (body[i]) frm.push_back(body[i]);
    endtask

    task automatic start_frame();
        rx_q.delete();
        sof_cnt  = 0;
        sof_pos  = -1;
        done_cnt = 0;
        last_ok  = 1'b0;
        last_len = '0;
    endtask

    // Drive frm; an optional two-cycle reset pulse starts at byte rst_at.
    task automatic send(input int gap, input int rst_at);
        for (int i = 0; i < frm.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_eq("rst_mid_valid", 64'(out_valid), 64'd0);
                check_eq("rst_mid_src",   64'(src_mac),   64'd0);
                check_eq("rst_mid_type",  64'(eth_type),  64'd0);
                check_eq("rst_mid_done",  64'(frame_done), 64'd0);
            end
            if (i == rst_at + 2) rst_n = 1'b1;
            gmii_rx_dv = 1'b1;
            gmii_rxd   = frm[i];
        end
        for (int i = 0; i < gap; i++) begin
            @(posedge clk);
            #1;
            gmii_rx_dv = 1'b0;
            gmii_rxd   = 8'h00;
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag, input int exp_n, input bit exp_done,
                               input bit exp_ok, input int exp_len);
        int bad = 0;
        check_eq({tag, "_nout"}, 64'(rx_q.size()), 64'(exp_n));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            if (rx_q[i] !== exp_q[i]) bad++;
        check_eq({tag, "_data"}, 64'(bad), 64'd0);
        check_eq({tag, "_sofcnt"}, 64'(sof_cnt), (exp_n > 0) ? 64'd1 : 64'd0);
        if (exp_n > 0) check_eq({tag, "_sofpos"}, 64'(sof_pos), 64'd0);
        check_eq({tag, "_done"}, 64'(done_cnt), exp_done ? 64'd1 : 64'd0);
        if (exp_done) begin
            check_eq({tag, "_ok"},  64'(last_ok),  64'(exp_ok));
            check_eq({tag, "_len"}, 64'(last_len), 64'(exp_len));
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        start_frame();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", 64'(out_valid),  64'd0);
        check_eq("rst_sof",   64'(out_sof),    64'd0);
        check_eq("rst_data",  64'(out_data),   64'd0);
        check_eq("rst_done",  64'(frame_done), 64'd0);
        check_eq("rst_ok",    64'(frame_ok),   64'd0);
        check_eq("rst_len",   64'(frame_len),  64'd0);
        check_eq("rst_type",  64'(eth_type),   64'd0);
        check_eq("rst_src",   64'(src_mac),    64'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Good 64-byte unicast frame.
        build(7, BOARD, SRC1, 16'h0800, 46, -1);
        start_frame(); send(4, -1); settle();
        check_frame("good", 46, 1, 1, 46);
        check_eq("good_type", 64'(eth_type), 64'h0800);
        check_eq("good_src",  64'(src_mac),  64'(SRC1));
        $display("frame good: out=%0d done=%0d ok=%0d len=%0d", rx_q.size(), done_cnt, last_ok, last_len);

        // One payload bit flipped after the FCS was computed.
        build(7, BOARD, SRC1, 16'h0800, 46, 10);
        start_frame(); send(4, -1); settle();
        check_frame("badcrc", 46, 1, 0, 46);
        $display("frame badcrc: out=%0d done=%0d ok=%0d", rx_q.size(), done_cnt, last_ok);

        // Foreign unicast dropped, broadcast right after accepted.
        build(7, 48'h00_11_22_33_44_66, SRC1, 16'h0800, 46, -1);
        start_frame(); send(1, -1); settle();
        check_frame("dstmiss", 0, 0, 0, 0);
        $display("frame dstmiss: out=%0d done=%0d", rx_q.size(), done_cnt);
        build(7, BCAST, SRC2, 16'h0806, 46, -1);
        start_frame(); send(4, -1); settle();
        check_frame("bcast", 46, 1, 1, 46);
        check_eq("bcast_type", 64'(eth_type), 64'h0806);
        check_eq("bcast_src",  64'(src_mac),  64'(SRC2));
        $display("frame bcast: out=%0d done=%0d ok=%0d", rx_q.size(), done_cnt, last_ok);

        // Preamble length variants.
        build(3, BOARD, SRC1, 16'h0800, 46, -1);
        start_frame(); send(4, -1); settle();
        check_frame("pre3", 46, 1, 1, 46);
        $display("frame pre3: done=%0d ok=%0d", done_cnt, last_ok);
        build(1, BOARD, SRC1, 16'h0800, 46, -1);
        start_frame(); send(4, -1); settle();
        check_frame("pre1", 46, 1, 1, 46);
        $display("frame pre1: done=%0d ok=%0d", done_cnt, last_ok);
        build(8, BOARD, SRC1, 16'h0800, 46, -1);
        start_frame(); send(4, -1); settle();
        check_frame("pre8", 0, 0, 0, 0);
        $display("frame pre8: out=%0d done=%0d", rx_q.size(), done_cnt);
        build(7, BOARD, SRC1, 16'h0800, 46, -1);
        frm[2] = 8'h54;
        start_frame(); send(4, -1); settle();
        check_frame("pre54", 0, 0, 0, 0);
        $display("frame pre54: out=%0d done=%0d", rx_q.size(), done_cnt);

        // Oversize (T=1600), runt (T=60) and empty (T=18) frames.
        build(7, BOARD, SRC1, 16'h0800, 1582, -1);
        start_frame(); send(4, -1); settle();
        check_frame("giant", 1500, 1, 0, 1500);
        $display("frame giant: out=%0d done=%0d ok=%0d len=%0d", rx_q.size(), done_cnt, last_ok, last_len);
        build(7, BOARD, SRC1, 16'h0800, 42, -1);
        start_frame(); send(4, -1); settle();
        check_frame("runt", 42, 1, 0, 42);
        $display("frame runt: out=%0d done=%0d ok=%0d len=%0d", rx_q.size(), done_cnt, last_ok, last_len);
        build(7, BOARD, SRC1, 16'h0800, 0, -1);
        start_frame(); send(4, -1); settle();
        check_frame("empty", 0, 1, 0, 0);
        $display("frame empty: done=%0d ok=%0d len=%0d", done_cnt, last_ok, last_len);

        // Reset pulse in the middle of the payload, then a clean frame.
        build(7, BOARD, SRC1, 16'h0800, 46, -1);
        start_frame(); send(4, 8 + 14 + 20); settle();
        check_eq("rstmid_done", 64'(done_cnt), 64'd0);
        $display("frame rstmid: done=%0d", done_cnt);
        build(7, BOARD, SRC2, 16'h0800, 46, -1);
        start_frame(); send(4, -1); settle();
        check_frame("afterrst", 46, 1, 1, 46);
        check_eq("afterrst_src", 64'(src_mac), 64'(SRC2));
        $display("frame afterrst: out=%0d done=%0d ok=%0d", rx_q.size(), done_cnt, last_ok);

        // Back-to-back frames separated by a single dv-low cycle.
        start_frame();
        build(7, BOARD, SRC1, 16'h0800, 46, -1);
        send(1, -1);
        build(7, BOARD, SRC2, 16'h0800, 50, -1);
        send(4, -1); settle();
        check_eq("b2b_done",   64'(done_cnt),    64'd2);
        check_eq("b2b_ok",     64'(last_ok),     64'd1);
        check_eq("b2b_len",    64'(last_len),    64'd50);
        check_eq("b2b_nout",   64'(rx_q.size()), 64'd96);
        check_eq("b2b_sofcnt", 64'(sof_cnt),     64'd2);
        check_eq("b2b_src",    64'(src_mac),     64'(SRC2));
        $display("frame b2b: out=%0d done=%0d ok=%0d len=%0d", rx_q.size(), done_cnt, last_ok, last_len);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gmii_rx_mac.md
Name: gmii_rx_mac

Overview:
Byte-level Ethernet MAC receive stage. It sits directly downstream of the RGMII-to-GMII DDR capture stage and consumes its byte stream. The block:
- strips preamble and SFD,
- parses and filters the 14-byte MAC header,
- verifies FCS (CRC-32),
- forwards only the payload, with the 4 FCS bytes removed, to the IP/UDP parser.

A per-frame status pulse reports the result.

Parameters:
BOARD_MAC, 48'h00_11_22_33_44_55, local unicast address accepted by the destination filter
MAX_FRAME, 1518, maximum bytes from destination MAC through FCS inclusive
MIN_FRAME, 64, minimum bytes from destination MAC through FCS inclusive

Ports:
clk  in  1  GMII receive clock, 125 MHz, driven from gmii_rx_clk
rst_n  in  1  asynchronous active-low reset
gmii_rx_dv  in  1  byte valid; contiguous high for the whole frame
gmii_rxd  in  8  received byte
out_valid  out  1  payload byte strobe
out_data  out  8  payload byte
out_sof  out  1  coincides with out_valid of the first payload byte
eth_type  out  16  EtherType of the current frame; stable from out_sof until the next header completes
src_mac  out  48  source MAC; same stability as eth_type
frame_done  out  1  one-cycle end-of-frame status pulse
frame_ok  out  1  valid only with frame_done: 1 = CRC good and length legal
frame_len  out  11  payload byte count excluding FCS; valid with frame_done

Behaviour:
Reset:
- All outputs are 0.
- State is IDLE; CRC register is 32'hFFFFFFFF.
- Reset takes effect mid-frame, with no done pulse.

State machine. Every state except IDLE samples only while gmii_rx_dv=1.
- IDLE: on dv=1 with byte 8'h55 -> PREAMBLE. On dv=1 with any other byte -> DROP.
- PREAMBLE: each 8'h55 increments a preamble count, which saturates at 7.
  - On 8'hD5 with count 1..7 -> HEADER.
  - Any other byte, or an 8th 8'h55 -> DROP.
  - dv low -> IDLE, silently.
- HEADER: captures 14 bytes MSB first (dst[47:0], src[47:0], type[15:0]), using a 4-bit counter.
  - After dst byte 6: if dst != BOARD_MAC and dst != 48'hFFFFFFFFFFFF -> DROP.
  - dv low before byte 14 -> IDLE, silently.
  - After byte 14: src_mac and eth_type update -> PAYLOAD.
- PAYLOAD: bytes pass through a 4-deep delay line.
  - Once the line holds 4 bytes, each new byte pushes the oldest out: out_valid=1, out_data=oldest, registered.
  - Latency: payload byte N appears at out_data 1 cycle after byte N+4 is sampled.
  - out_sof accompanies the first pushed-out byte.
  - The 4 bytes left in the line when dv falls are the FCS and are never output.
  - On the dv falling edge (first cycle with dv=0): frame_done=1 for one cycle; frame_len = payload bytes output; state -> IDLE.
- DROP: ignore input until dv=0, then -> IDLE. No frame_done, no out_valid.

CRC:
- Reflected CRC-32, polynomial 04C11DB7, init FFFFFFFF.
- Covers dst MAC through FCS inclusive.
- Good frame iff the register equals residue 32'hC704DD7B at the dv falling edge.
- Reinitialised on SFD.

Frame length:
- Total length T = 14 + frame_len + 4.
- frame_ok = crc_good AND T >= MIN_FRAME AND T <= MAX_FRAME.
- When T would exceed MAX_FRAME in PAYLOAD: stop out_valid, set a sticky error, continue to the dv fall, then emit frame_done with frame_ok=0 and frame_len saturated at MAX_FRAME-18.

Boundary conditions:
- Frame with 0 payload bytes (T=18): frame_done with frame_ok=0 (runt); out_sof never asserts.
- dv high again the cycle right after frame_done: treated as a new IDLE sample.
- out_valid never asserts on consecutive-frame boundaries without an intervening frame_done.

Decomposition:
- Shared package eth_pkg: constants PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5, CRC_INIT 32'hFFFFFFFF, CRC_RESIDUE 32'hC704DD7B, BCAST_MAC, HDR_LEN 14, FCS_LEN 4; state enum for the block.
- One sub-module crc32_d8: combinational next-CRC for an 8-bit reflected input, reused later by the transmit MAC.

Test Plan:
- Good 64-byte unicast frame: 7x55, D5, dst=BOARD_MAC, src=0A0B0C0D0E0F, type=0800, 46 payload bytes 00..2D, correct FCS -> 46 out_valid bytes 00..2D, out_sof on byte 00, eth_type=0800, src_mac=0A0B0C0D0E0F, then frame_done=1, frame_ok=1, frame_len=46.
- Same frame with one payload bit flipped -> 46 bytes output, frame_done=1, frame_ok=0.
- Dst=001122334466 -> no out_valid, no frame_done. A broadcast frame immediately after -> accepted, frame_ok=1.
- Preamble of 3x55 then D5 -> accepted. Byte 8'h54 inside the preamble -> dropped silently.
- 1600-byte frame -> out_valid stops after 1500 bytes, frame_done with frame_ok=0 and frame_len=1500. Short frame with T=60 -> frame_ok=0, frame_len=42.
- rst_n low mid-payload for 2 cycles -> all outputs 0 immediately and no frame_done; the next good frame is received correctly.
